// File: rtl/score_display.sv
// score_display: binary score to time-multiplexed common-anode seven-segment
// display, with sequential double-dabble BCD conversion (saturating), hex mode,
// leading-zero blanking, per-digit decimal points and whole-display blink.
module score_display #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 17,
  parameter int BLINK_DIV = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] score,
  input  logic                dec_mode,
  input  logic                blank_lz,
  input  logic                blink_en,
  input  logic [DIGITS-1:0]   dp_mask,
  output logic                busy,
  output logic [DIGITS-1:0]   AN,
  output logic [7:0]          SEGMENT
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MAXDEC = W'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LOAD
  } state_t;

  state_t          state, state_nxt;
  logic            capture;
  logic [W-1:0]    sh_score;
  logic            sh_dec;
  logic [W-1:0]    bin_sr;
  logic [W-1:0]    bcd;
  logic [W-1:0]    bcd_adj;
  logic [W-1:0]    nines;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    disp;

  logic [SCAN_DIV-1:0]  scan_cnt;
  logic [IW-1:0]        idx;
  logic [BLINK_DIV-1:0] blink_cnt;
  logic                 phase;

  logic [DIGITS-1:0] lz;
  logic              zero_run;
  logic [3:0]        cur_digit;

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

  // Conversion FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a new score/mode is only accepted in IDLE
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if ((score != sh_score) || (dec_mode != sh_dec)) begin
          capture   = 1'b1;
          state_nxt = dec_mode ? CONVERT : LOAD;
        end
      end
      CONVERT: begin
        if (cnt == CW'(W - 1)) state_nxt = LOAD;
      end
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Double-dabble add-3 correction and the saturation constant
  always_comb begin
    bcd_adj = '0;
    nines   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
      nines[4*i +: 4]   = 4'd9;
    end
  end

  // Shadows, conversion shift registers and the display register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_score <= '0;
      sh_dec   <= 1'b1;
      bin_sr   <= '0;
      bcd      <= '0;
      cnt      <= '0;
      disp     <= '0;
    end else begin
      if (capture) begin
        sh_score <= score;
        sh_dec   <= dec_mode;
        bin_sr   <= score;
        bcd      <= '0;
        cnt      <= '0;
      end else if (state == CONVERT) begin
        bin_sr <= bin_sr << 1;
        bcd    <= {bcd_adj[W-2:0], bin_sr[W-1]};
        cnt    <= cnt + 1'b1;
      end else if (state == LOAD) begin
        if (sh_dec) disp <= (sh_score > MAXDEC) ? nines : bcd;
        else        disp <= sh_score;
      end
    end
  end

  // Scan prescaler and active digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (&scan_cnt) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Free-running blink prescaler and phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      if (&blink_cnt) phase <= ~phase;
    end
  end

  // Leading-zero mask: a digit is blanked while every digit from it upward is zero
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (disp[4*i +: 4] == 4'd0);
      lz[i]    = zero_run & blank_lz;
    end
    cur_digit = disp[4*int'(idx) +: 4];
  end

  // Registered AN/SEGMENT drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AN      <= '1;
      SEGMENT <= 8'hFF;
    end else begin
      AN      <= (blink_en && !phase) ? '1 : ~(DIGITS'(1) << idx);
      SEGMENT <= {~dp_mask[idx], lz[idx] ? 7'h7F : font(cur_digit)};
    end
  end

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: randomized and directed checks of score_display against a
// behavioural model of what each digit should show.
module tb_score_display;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [W-1:0]      score;
  logic              dec_mode;
  logic              blank_lz;
  logic              blink_en;
  logic [DIGITS-1:0] dp_mask;
  logic              busy;
  logic [DIGITS-1:0] AN;
  logic [7:0]        SEGMENT;

  int n_cmp = 0;
  int n_err = 0;

  // model of the accepted score/mode
  int unsigned m_score;
  logic        m_dec;

  score_display #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (2),
    .BLINK_DIV(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .score   (score),
    .dec_mode(dec_mode),
    .blank_lz(blank_lz),
    .blink_en(blink_en),
    .dp_mask (dp_mask),
    .busy    (busy),
    .AN      (AN),
    .SEGMENT (SEGMENT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int unsigned d);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[d];
  endfunction

  function automatic logic [7:0] exp_seg(input int unsigned i);
    int unsigned v, base, p, d;
    logic        blank;
    base = m_dec ? 10 : 16;
    v    = (m_dec && m_score > 9999) ? 9999 : m_score;
    p    = base ** i;
    d    = (v / p) % base;
    blank = blank_lz && (i > 0) && (v < p);
    return {~dp_mask[i], blank ? 7'h7F : glyph(d)};
  endfunction

  // One full refresh: every sample must be one digit, correct glyph, 4 samples per digit
  task automatic observe(input string tag);
    int cntd [DIGITS];
    int found;
    foreach (cntd[k]) cntd[k] = 0;
    for (int s = 0; s < 4 * DIGITS; s++) begin
      @(negedge clk);
      found = -1;
      for (int k = 0; k < DIGITS; k++)
        if (AN == ~(DIGITS'(1) << k)) found = k;
      if (found < 0) check({tag, "_an_onehot"}, 32'(AN), 32'hE);
      else begin
        check({tag, "_seg"}, 32'(SEGMENT), 32'(exp_seg(found)));
        cntd[found]++;
      end
    end
    for (int k = 0; k < DIGITS; k++) check({tag, "_scan_count"}, cntd[k], 4);
  endtask

  task automatic measure_busy(input string tag, input int exp);
    int n;
    n = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) break;
    end
    check(tag, n, exp);
  endtask

  task automatic run_update(input string tag, input int unsigned s, input logic d,
                            input logic b, input logic [DIGITS-1:0] dp);
    bit chg;
    int n;
    @(negedge clk);
    score = W'(s); dec_mode = d; blank_lz = b; dp_mask = dp;
    chg = (s != m_score) || (d != m_dec);
    if (chg) measure_busy({tag, "_busy_len"}, d ? W + 1 : 1);
    else begin
      n = 0;
      repeat (3) begin @(negedge clk); if (busy) n++; end
      check({tag, "_busy_idle"}, n, 0);
    end
    m_score = s; m_dec = d;
    repeat (2) @(negedge clk);
    observe(tag);
  endtask

  initial begin
    int run, maxrun, ones;
    rst_n = 1'b0; score = '0; dec_mode = 1'b1; blank_lz = 1'b1;
    blink_en = 1'b0; dp_mask = '0;
    m_score = 0; m_dec = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_an", 32'(AN), 32'hF);
    check("rst_seg", 32'(SEGMENT), 32'hFF);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    observe("zero");

    run_update("d1234", 1234, 1'b1, 1'b1, 4'b0000);
    run_update("sat", 12345, 1'b1, 1'b1, 4'b0000);
    run_update("seven", 7, 1'b1, 1'b1, 4'b0000);
    run_update("hex", 16'hBEEF, 1'b0, 1'b0, 4'b0100);
    run_update("max_dec", 9999, 1'b1, 1'b0, 4'b1001);
    run_update("over_dec", 10000, 1'b1, 1'b1, 4'b0000);

    // change mid-conversion: first result completes, then a second full conversion
    @(negedge clk);
    score = 16'd1234; dec_mode = 1'b1; blank_lz = 1'b0; dp_mask = 4'b0000;
    begin
      int n;
      n = 0;
      for (int t = 0; t < 60; t++) begin
        @(negedge clk);
        if (t == 5) score = 16'd5678;
        if (busy) n++;
        else if (n > 0) break;
      end
      check("mid_first_busy", n, W + 1);
    end
    measure_busy("mid_second_busy", W + 1);
    m_score = 5678; m_dec = 1'b1;
    repeat (2) @(negedge clk);
    observe("mid_5678");

    // reset mid-conversion
    @(negedge clk);
    score = 16'd4321;
    repeat (5) @(negedge clk);
    check("mid_busy_before_rst", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_an", 32'(AN), 32'hF);
    check("midrst_seg", 32'(SEGMENT), 32'hFF);
    check("midrst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    m_score = 0; m_dec = 1'b1;
    rst_n = 1'b1;
    measure_busy("post_rst_conv", W + 1);
    m_score = 4321;
    repeat (2) @(negedge clk);
    observe("after_rst");

    // blink: 16 blank cycles alternate with 16 scanning cycles
    @(negedge clk);
    blink_en = 1'b1;
    repeat (2) @(negedge clk);
    run = 0; maxrun = 0; ones = 0;
    for (int s = 0; s < 64; s++) begin
      @(negedge clk);
      if (AN == '1) begin
        ones++; run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
    end
    check("blink_dark_cycles", ones, 32);
    check("blink_window", maxrun, 16);
    @(negedge clk);
    blink_en = 1'b0;
    repeat (2) @(negedge clk);
    observe("blink_off");

    // randomized updates
    for (int it = 0; it < 30; it++) begin
      int unsigned s;
      case ($urandom_range(0, 3))
        0: s = $urandom_range(0, 99);
        1: s = $urandom_range(0, 9999);
        2: s = $urandom_range(0, 65535);
        default: s = m_score;
      endcase
      run_update("rand", s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 DIGITS'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/score_display.md
# score_display

Parametrised multi-digit seven-segment score driver. Takes a binary score and shows it in decimal or hexadecimal on a time-multiplexed common-anode display. Adds sequential binary-to-BCD conversion with saturation, leading-zero blanking, per-digit decimal points and whole-display blinking. It sits between the game-logic score register and the board's AN/SEGMENT pins and replaces the fixed 4-digit hex display path.

## Interface
- DIGITS, 4: number of display digits, 1..8; score width W = 4*DIGITS.
- SCAN_DIV, 17: scan prescaler width; the active digit advances every 2^SCAN_DIV clocks.
- BLINK_DIV, 24: blink prescaler width; the blink phase toggles every 2^BLINK_DIV clocks.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- score  in  W  binary score, unsigned.
- dec_mode  in  1  1 = decimal display, 0 = hex display.
- blank_lz  in  1  1 = blank leading zeros.
- blink_en  in  1  1 = blink the whole display.
- dp_mask  in  DIGITS  1 = light the decimal point of that digit; bit 0 is the rightmost digit.
- busy  out  1  high while a conversion is in progress.
- AN  out  DIGITS  active-low one-hot digit enable; bit 0 is the rightmost digit.
- SEGMENT  out  8  active-low segments; bit0..bit6 = a..g, bit7 = dp.

## Operation
- Shadow registers hold the last accepted score and dec_mode.
- Conversion FSM has three states: IDLE, CONVERT, LOAD.
- IDLE: if score != shadow or dec_mode != shadow:
  - capture both into the shadows;
  - if dec_mode=1, go to CONVERT; else go to LOAD.
  - busy=1 from the next cycle.
- CONVERT runs sequential double-dabble, one shift per cycle, exactly W cycles. Then go to LOAD.
- LOAD:
  - writes the display register, then returns to IDLE with busy=0;
  - decimal mode: BCD result, or all digits = 9 if shadow score > 10^DIGITS-1;
  - hex mode: shadow score nibbles directly.
- Input changes during CONVERT/LOAD are ignored. They are re-detected on return to IDLE, so only complete results are ever displayed.
- Scan: a SCAN_DIV-bit prescaler wraps, and on each wrap the digit index increments, wrapping DIGITS-1 -> 0.
  - AN = ~(1 << index).
- Font: standard hex, e.g. 0 -> 0x40, 1 -> 0x79, 4 -> 0x19, 9 -> 0x10, B -> 0x03, E -> 0x06, F -> 0x0E on bits 6..0.
- bit7 = ~dp_mask[index].
- Blanking (blank_lz=1): digits above the most significant nonzero digit show 0x7F on bits 6..0. Digit 0 is never blanked, and dp still follows dp_mask.
- Blink: a free-running BLINK_DIV-bit prescaler toggles phase on wrap. When blink_en=1 and phase=0, AN = all ones. blink_en=0 forces the display on.
- Reset state:
  - AN = all ones, SEGMENT = 0xFF, busy = 0;
  - FSM IDLE, display register 0, shadows 0 / dec_mode shadow 1;
  - digit index 0, both prescalers 0.

## Timing
- AN/SEGMENT are registered outputs with one cycle of latency from index change.
- Decimal mode: change sampled at edge k.
  - busy=1 after edges k..k+W;
  - display register valid after edge k+W+1;
  - busy=0 after edge k+W+1.
- Hex mode: display register valid after edge k+1; busy high for one cycle.
- Reset asserted mid-conversion: outputs go to reset values immediately, with no partial result. After release, a nonzero score triggers a fresh conversion.
- Digit refresh period = DIGITS * 2^SCAN_DIV clocks.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=2, BLINK_DIV=4.

1. Reset release, score=0, dec_mode=1, blank_lz=1, dp_mask=0: during reset AN=4'b1111, SEGMENT=0xFF; after reset digit0 shows 0xC0 and digits 1-3 show 0xFF.
2. score=1234 decimal, blank_lz=1: busy high exactly 17 cycles. Scan shows digit3..0 = 0xF9, 0xA4, 0xB0, 0x99.
3. score=12345 decimal: all four digits show 0x90 (saturated 9999). Then score=7, blank_lz=1: digit0=0xF8 and digits 1-3 = 0xFF.
4. score=16'hBEEF, dec_mode=0, blank_lz=0, dp_mask=4'b0100: busy high 1 cycle; digits show 0x83, 0x06, 0x86, 0x8E (digit2 with dp lit).
5. score=1234, then 5678 five cycles into CONVERT: the display shows 1234, then 5678 after a second full conversion, and no other value ever appears. Assert rst_n low mid-conversion: AN=4'b1111 at once.
6. blink_en=1: AN is all ones for 16-cycle windows alternating with 16 cycles of normal scan. blink_en=0 restores continuous scan.
